// File: rtl/soc_clk_divider_multi.sv
// Multi-channel programmable clock divider: registered divided clocks plus tick
// strobes, with per-channel ratio handshake, clean start/stop and shared phase sync.
module soc_clk_divider_multi #(
    parameter int NumCh      = 2,
    parameter int CntWidth   = 16,
    parameter int DefaultDiv = 50
) (
    input  logic                      soc_clk,
    input  logic                      rst_n,
    input  logic [NumCh-1:0]          en_i,
    input  logic                      sync_i,
    input  logic [NumCh*CntWidth-1:0] div_i,
    input  logic [NumCh-1:0]          div_valid_i,
    output logic [NumCh-1:0]          div_ready_o,
    output logic [NumCh-1:0]          clk_o,
    output logic [NumCh-1:0]          tick_o,
    output logic [NumCh*CntWidth-1:0] div_o
);

    localparam int DefClamped = (DefaultDiv < 2) ? 2 : DefaultDiv;
    localparam logic [CntWidth-1:0] DefDiv = DefClamped[CntWidth-1:0];
    localparam logic [CntWidth-1:0] One    = CntWidth'(1);
    localparam logic [CntWidth-1:0] Two    = CntWidth'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // High phase length is ceil(D/2), computed without needing a wider adder.
    function automatic logic [CntWidth-1:0] half_up(input logic [CntWidth-1:0] d);
        return (d >> 1) + CntWidth'(d[0]);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NumCh; gi++) begin : g_ch
            state_t              state_reg, state_next;
            logic [CntWidth-1:0] cnt_reg, cnt_next;
            logic [CntWidth-1:0] act_reg, act_next;
            logic [CntWidth-1:0] shd_reg, shd_next;
            logic                pend_reg, pend_next;
            logic                clk_reg, clk_next;
            logic                tick_reg, tick_next;
            logic [CntWidth-1:0] req;
            logic [CntWidth-1:0] req_clamped;
            logic                last;
            logic                xfer;
            logic                start;
            logic                apply;

            assign req         = div_i[gi*CntWidth +: CntWidth];
            assign req_clamped = (req < Two) ? Two : req;
            assign last        = (cnt_reg == act_reg - One);
            assign xfer        = div_valid_i[gi] && !pend_reg;

            always_ff @(posedge soc_clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    act_reg   <= DefDiv;
                    shd_reg   <= DefDiv;
                    pend_reg  <= 1'b0;
                    clk_reg   <= 1'b0;
                    tick_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    act_reg   <= act_next;
                    shd_reg   <= shd_next;
                    pend_reg  <= pend_next;
                    clk_reg   <= clk_next;
                    tick_reg  <= tick_next;
                end
            end

            // Next state and period-start detection; sync beats wrap beats count.
            always_comb begin
                state_next = state_reg;
                start      = 1'b0;
                unique case (state_reg)
                    IDLE: begin
                        if (en_i[gi]) begin
                            state_next = RUN;
                            start      = 1'b1;
                        end
                    end
                    RUN: begin
                        if (sync_i) begin
                            start      = 1'b1;
                            state_next = en_i[gi] ? RUN : STOP;
                        end else if (last) begin
                            if (en_i[gi]) begin
                                start = 1'b1;
                            end else begin
                                state_next = IDLE;
                            end
                        end else if (!en_i[gi]) begin
                            state_next = STOP;
                        end
                    end
                    STOP: begin
                        if (last) begin
                            if (en_i[gi]) begin
                                start      = 1'b1;
                                state_next = RUN;
                            end else begin
                                state_next = IDLE;
                            end
                        end else if (en_i[gi]) begin
                            state_next = RUN;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end

            // Datapath: an idle channel adopts a pending ratio immediately, a
            // running one only at the start of its next period.
            always_comb begin
                apply     = start || (state_reg == IDLE);
                act_next  = (apply && pend_reg) ? shd_reg : act_reg;
                shd_next  = xfer ? req_clamped : shd_reg;
                pend_next = xfer ? 1'b1 : (apply ? 1'b0 : pend_reg);
                cnt_next  = cnt_reg;
                clk_next  = clk_reg;
                tick_next = 1'b0;
                if (start) begin
                    cnt_next  = '0;
                    clk_next  = 1'b1;
                    tick_next = 1'b1;
                end else if (state_next == IDLE) begin
                    cnt_next = '0;
                    clk_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + One;
                    clk_next = (cnt_next < half_up(act_next));
                end
            end

            assign clk_o[gi]                        = clk_reg;
            assign tick_o[gi]                       = tick_reg;
            assign div_ready_o[gi]                  = ~pend_reg;
            assign div_o[gi*CntWidth +: CntWidth]   = act_reg;
        end
    endgenerate

endmodule
